// File: rtl/uart_core_param.sv
`timescale 1ns/1ps
// Full-duplex UART with parametrised frame (data bits, parity, stop bits),
// valid/ready handshakes and per-byte parity/frame error plus overrun reporting.
module uart_core_param #(
  parameter int CLK_FREQ  = 40000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT*2+1);
  localparam int BW           = $clog2(DATA_BITS+1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT-1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);
  localparam logic          ODD      = (PARITY == 1);
  localparam logic          HAS_PAR  = (PARITY != 0);

  generate
    if (CLKS_PER_BIT < 4) begin : gBadBaud
      $error("uart_core_param: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
      $error("uart_core_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : gBadParity
      $error("uart_core_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
      $error("uart_core_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} txState_t;

  txState_t             txState;
  logic [CW-1:0]        txCnt;
  logic [BW-1:0]        txBitCnt;
  logic [DATA_BITS-1:0] txShift;
  logic                 txPar;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState  <= TX_IDLE;
      txCnt    <= '0;
      txBitCnt <= '0;
      txShift  <= '0;
      txPar    <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (txState)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            txShift  <= tx_data;
            txPar    <= ODD ? ~^tx_data : ^tx_data;
            txCnt    <= '0;
            txBitCnt <= '0;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            txState  <= TX_START;
          end
        end
        TX_START: begin
          if (txCnt == BIT_END) begin
            txCnt   <= '0;
            txd     <= txShift[0];
            txState <= TX_DATA;
          end else txCnt <= txCnt + 1'b1;
        end
        TX_DATA: begin
          if (txCnt == BIT_END) begin
            txCnt <= '0;
            if (txBitCnt == LAST_BIT) begin
              txd     <= HAS_PAR ? txPar : 1'b1;
              txState <= HAS_PAR ? TX_PAR : TX_STOP;
            end else begin
              // txd is one bit ahead of the shifter's LSB
              txd      <= txShift[1];
              txShift  <= txShift >> 1;
              txBitCnt <= txBitCnt + 1'b1;
            end
          end else txCnt <= txCnt + 1'b1;
        end
        TX_PAR: begin
          if (txCnt == BIT_END) begin
            txCnt   <= '0;
            txd     <= 1'b1;
            txState <= TX_STOP;
          end else txCnt <= txCnt + 1'b1;
        end
        TX_STOP: begin
          if (txCnt == STOP_END) begin
            txCnt    <= '0;
            tx_ready <= 1'b1;
            txState  <= TX_IDLE;
          end else txCnt <= txCnt + 1'b1;
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rxState_t;

  logic                 rxSync1, rxSync2;
  rxState_t             rxState;
  logic [CW-1:0]        rxCnt;
  logic [BW-1:0]        rxBitCnt;
  logic [DATA_BITS-1:0] rxShift;
  logic                 rxParBit;
  logic                 rxParErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
    end else begin
      rxSync1 <= rxd;
      rxSync2 <= rxSync1;
    end
  end

  // XOR over data+parity is 0 for even, 1 for odd on a clean frame
  assign rxParErr = HAS_PAR & (^rxShift ^ rxParBit ^ ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxState       <= RX_IDLE;
      rxCnt         <= '0;
      rxBitCnt      <= '0;
      rxShift       <= '0;
      rxParBit      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (rxState)
        RX_IDLE: begin
          if (!rxSync2) begin
            rxCnt   <= '0;
            rxState <= RX_START;
          end
        end
        RX_START: begin
          if (rxCnt == HALF_END) begin
            rxCnt    <= '0;
            rxBitCnt <= '0;
            rxState  <= rxSync2 ? RX_IDLE : RX_DATA;
          end else rxCnt <= rxCnt + 1'b1;
        end
        RX_DATA: begin
          if (rxCnt == BIT_END) begin
            rxCnt   <= '0;
            rxShift <= {rxSync2, rxShift[DATA_BITS-1:1]};
            if (rxBitCnt == LAST_BIT) rxState <= HAS_PAR ? RX_PAR : RX_STOP;
            else rxBitCnt <= rxBitCnt + 1'b1;
          end else rxCnt <= rxCnt + 1'b1;
        end
        RX_PAR: begin
          if (rxCnt == BIT_END) begin
            rxCnt    <= '0;
            rxParBit <= rxSync2;
            rxState  <= RX_STOP;
          end else rxCnt <= rxCnt + 1'b1;
        end
        RX_STOP: begin
          if (rxCnt == BIT_END) begin
            rxCnt <= '0;
            // a consume in this same cycle frees the slot for the new frame
            if (!rx_valid || rx_ready) begin
              rx_data       <= rxShift;
              rx_parity_err <= rxParErr;
              rx_frame_err  <= !rxSync2;
              rx_valid      <= 1'b1;
            end else rx_overrun <= 1'b1;
            rxState <= rxSync2 ? RX_IDLE : RX_BREAK;
          end else rxCnt <= rxCnt + 1'b1;
        end
        RX_BREAK: if (rxSync2) rxState <= RX_IDLE;
        default: rxState <= RX_IDLE;
      endcase
    end
  end

endmodule
